// File: rtl/udma_tx_stream_sim.sv
// udma_tx_stream_sim: uDMA-side TX channel model in front of the UART TX path.
// Words pushed by the sequence are buffered in a FIFO. The UART's req/gnt
// address phase is served from buffered words that are not yet granted.
// Each grant becomes a valid data beat VALID_LATENCY cycles later. The
// valid/ready data phase then pops the FIFO head.
module udma_tx_stream_sim #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 16,
    parameter int VALID_LATENCY   = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TRANS_SIZE      = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          rstn_i,
    input  logic                          push_valid_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    output logic                          push_ready_o,
    input  logic                          flush_i,
    input  logic                          data_tx_req_i,
    output logic                          data_tx_gnt_o,
    output logic [DATA_WIDTH-1:0]         data_tx_o,
    output logic                          data_tx_valid_o,
    input  logic                          data_tx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [TRANS_SIZE-1:0]         sent_count_o,
    output logic                          busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [LW-1:0]         r_outst;
    logic [LW-1:0]         r_matured;
    logic [TRANS_SIZE-1:0] r_sent;
    logic                  r_alive;

    logic w_push;
    logic w_pop;
    logic w_gnt;
    logic w_mature;
    logic w_valid;

    // Handshake qualifiers; flush overrides push, grant and pop.
    // r_alive keeps push_ready low until the first clock after reset.
    assign w_valid      = (r_matured != '0);
    assign push_ready_o = r_alive & (r_level < LW'(FIFO_DEPTH));
    assign w_push       = push_valid_i & push_ready_o & ~flush_i;
    assign w_gnt        = data_tx_req_i & (r_level > r_outst)
                        & (r_outst < LW'(MAX_OUTSTANDING)) & ~flush_i;
    assign w_pop        = w_valid & data_tx_ready_i & ~flush_i;

    assign data_tx_gnt_o   = w_gnt;
    assign data_tx_valid_o = w_valid;
    assign data_tx_o       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level_o    = r_level;
    assign sent_count_o    = r_sent;
    assign busy_o          = (r_level != '0) | (r_outst != '0);

    // FIFO storage; no reset needed since the head is masked while not valid
    always_ff @(posedge sys_clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= push_data_i;
    end

    // Grant-to-data latency line: the grant itself counts as the first stage
    generate
        if (VALID_LATENCY == 1) begin : g_nopipe
            assign w_mature = w_gnt;
        end else begin : g_pipe
            logic [VALID_LATENCY-2:0] r_pipe;
            // Shift accepted grants; flush drops everything still in flight
            always_ff @(posedge sys_clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_pipe <= '0;
                end else if (flush_i) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= w_gnt;
                    for (int i = 1; i < VALID_LATENCY - 1; i++)
                        r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_mature = r_pipe[VALID_LATENCY-2];
        end
    endgenerate

    // Pointers, level, outstanding grants and matured beats
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_outst   <= '0;
            r_matured <= '0;
        end else if (flush_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_outst   <= '0;
            r_matured <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level   <= r_level   + LW'(w_push)   - LW'(w_pop);
            r_outst   <= r_outst   + LW'(w_gnt)    - LW'(w_pop);
            r_matured <= r_matured + LW'(w_mature) - LW'(w_pop);
        end
    end

    // Delivered-word counter survives flush and wraps naturally
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_sent <= '0;
        else if (w_pop)
            r_sent <= r_sent + 1'b1;
    end

    // Push side stays closed until the first clock after reset release
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_alive <= 1'b0;
        else
            r_alive <= 1'b1;
    end

    a_hold: assert property (@(posedge sys_clk_i) disable iff (!rstn_i)
        (w_valid && !data_tx_ready_i && !flush_i) |=> (w_valid && $stable(data_tx_o)));
    a_max_outst: assert property (@(posedge sys_clk_i) disable iff (!rstn_i)
        r_outst <= LW'(MAX_OUTSTANDING));
    a_outst_level: assert property (@(posedge sys_clk_i) disable iff (!rstn_i)
        r_outst <= r_level);

endmodule

// File: tb/tb_udma_tx_stream_sim.sv
// tb_udma_tx_stream_sim: directed scenarios plus randomized traffic.
// A reference model tracks level, grants and latency with plain counters
// and a queue of remaining delays. A scoreboard queue holds expected
// words, and a monitor checks each one as the DUT presents it.
module tb_udma_tx_stream_sim;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int VLAT  = 1;
    localparam int MAXO  = 2;
    localparam int TS    = 16;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          push_valid_i = 1'b0;
    logic [DW-1:0] push_data_i = '0;
    logic          push_ready_o;
    logic          flush_i = 1'b0;
    logic          data_tx_req_i = 1'b0;
    logic          data_tx_gnt_o;
    logic [DW-1:0] data_tx_o;
    logic          data_tx_valid_o;
    logic          data_tx_ready_i = 1'b0;
    logic [4:0]    fifo_level_o;
    logic [TS-1:0] sent_count_o;
    logic          busy_o;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int            m_level, m_out, m_mat, m_sent;
    bit            m_alive;
    int            m_gr[$];
    logic [DW-1:0] sb_q[$];

    udma_tx_stream_sim #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .VALID_LATENCY(VLAT),
        .MAX_OUTSTANDING(MAXO), .TRANS_SIZE(TS)
    ) dut (
        .sys_clk_i(clk), .rstn_i(rstn_i),
        .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
        .flush_i(flush_i),
        .data_tx_req_i(data_tx_req_i), .data_tx_gnt_o(data_tx_gnt_o),
        .data_tx_o(data_tx_o), .data_tx_valid_o(data_tx_valid_o), .data_tx_ready_i(data_tx_ready_i),
        .fifo_level_o(fifo_level_o), .sent_count_o(sent_count_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!data_tx_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("wait_valid", data_tx_valid_o, 1'b1);
    endtask

    // Reference model: compare at negedge, then advance to the next edge's state
    initial forever begin
        @(negedge clk);
        if (!rstn_i) begin
            m_level = 0; m_out = 0; m_mat = 0; m_sent = 0; m_alive = 0;
            m_gr.delete();
            sb_q.delete();
        end else begin
            chk("gnt", data_tx_gnt_o,
                data_tx_req_i && (m_level > m_out) && (m_out < MAXO) && !flush_i);
            chk("valid", data_tx_valid_o, m_mat > 0);
            chk("push_ready", push_ready_o, m_alive && (m_level < DEPTH));
            chk("level", fifo_level_o, m_level);
            chk("sent", sent_count_o, m_sent);
            chk("busy", busy_o, (m_level != 0) || (m_out != 0));
            #1;
            if (flush_i) begin
                m_level = 0; m_out = 0; m_mat = 0;
                m_gr.delete();
                sb_q.delete();
            end else begin
                bit acc, g, p;
                acc = push_valid_i && m_alive && (m_level < DEPTH);
                g   = data_tx_req_i && (m_level > m_out) && (m_out < MAXO);
                p   = (m_mat > 0) && data_tx_ready_i;
                if (acc) sb_q.push_back(push_data_i);
                m_level = m_level + int'(acc) - int'(p);
                m_out   = m_out + int'(g) - int'(p);
                m_mat   = m_mat - int'(p);
                m_sent  = (m_sent + int'(p)) % (1 << TS);
                if (g) m_gr.push_back(VLAT);
                for (int i = 0; i < m_gr.size(); i++) m_gr[i] = m_gr[i] - 1;
                while (m_gr.size() > 0 && m_gr[0] == 0) begin
                    void'(m_gr.pop_front());
                    m_mat++;
                end
            end
            m_alive = 1;
        end
    end

    // Monitor: data must be the oldest expected word while valid, 0 otherwise
    initial forever begin
        @(negedge clk);
        if (rstn_i) begin
            if (data_tx_valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("data_unexpected", data_tx_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("data", data_tx_o, sb_q[0]);
                    if (data_tx_ready_i && !flush_i) void'(sb_q.pop_front());
                end
            end else begin
                chk("data_idle", data_tx_o, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent_snap;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_push_ready", push_ready_o, 1'b0);
        chk("rst_level", fifo_level_o, '0);
        chk("rst_valid", data_tx_valid_o, 1'b0);
        chk("rst_sent", sent_count_o, '0);
        rstn_i = 1'b1;
        chk("rel_push_ready", push_ready_o, 1'b0);
        tick();
        chk("ready_after_rst", push_ready_o, 1'b1);

        // 1: single word, latency 1
        push_valid_i = 1; push_data_i = 32'hA5; data_tx_req_i = 1; data_tx_ready_i = 1;
        tick();
        push_valid_i = 0;
        chk("t1_gnt", data_tx_gnt_o, 1'b1);
        tick();
        chk("t1_valid", data_tx_valid_o, 1'b1);
        chk("t1_data", data_tx_o, 32'hA5);
        tick();
        chk("t1_sent", sent_count_o, 16'd1);
        chk("t1_level", fifo_level_o, '0);

        // 2: four words with req always high
        for (int i = 0; i < 4; i++) begin
            push_valid_i = 1; push_data_i = 32'h100 + i;
            tick();
        end
        push_valid_i = 0;
        repeat (8) tick();
        chk("t2_sent", sent_count_o, 16'd5);
        chk("t2_busy", busy_o, 1'b0);

        // 3: fill, stall a 17th push, then steady push+pop
        data_tx_req_i = 0; data_tx_ready_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            push_valid_i = 1; push_data_i = $urandom;
            tick();
        end
        push_data_i = 32'hDEAD_0017;
        repeat (2) tick();
        chk("t3_full_ready", push_ready_o, 1'b0);
        chk("t3_full_level", fifo_level_o, 5'd16);
        data_tx_req_i = 1; data_tx_ready_i = 1;
        repeat (6) tick();
        chk("t3_pushpop_level", fifo_level_o, 5'd15);
        push_valid_i = 0;
        repeat (40) tick();
        chk("t3_drained", fifo_level_o, '0);

        // 4: ready held low keeps data stable, then one pop
        data_tx_ready_i = 0;
        push_valid_i = 1; push_data_i = 32'h0BAD_F00D;
        tick();
        push_valid_i = 0;
        wait_valid();
        repeat (5) tick();
        chk("t4_hold_valid", data_tx_valid_o, 1'b1);
        chk("t4_hold_data", data_tx_o, 32'h0BAD_F00D);
        data_tx_ready_i = 1;
        tick();
        chk("t4_single_pop", data_tx_valid_o, 1'b0);
        chk("t4_level", fifo_level_o, '0);
        data_tx_ready_i = 0; data_tx_req_i = 0;

        // 5: flush with 3 words and one grant in flight
        for (int i = 0; i < 3; i++) begin
            push_valid_i = 1; push_data_i = 32'h500 + i;
            tick();
        end
        push_valid_i = 0;
        data_tx_req_i = 1;
        tick();
        data_tx_req_i = 0;
        sent_snap = m_sent;
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("t5_level", fifo_level_o, '0);
        chk("t5_valid", data_tx_valid_o, 1'b0);
        chk("t5_sent", sent_count_o, sent_snap);

        // 6: async reset while valid
        data_tx_req_i = 1;
        push_valid_i = 1; push_data_i = 32'h600D;
        tick();
        push_valid_i = 0;
        wait_valid();
        rstn_i = 0;
        #1;
        chk("t6_valid", data_tx_valid_o, 1'b0);
        chk("t6_data", data_tx_o, '0);
        chk("t6_gnt", data_tx_gnt_o, 1'b0);
        chk("t6_ready", push_ready_o, 1'b0);
        chk("t6_level", fifo_level_o, '0);
        chk("t6_sent", sent_count_o, '0);
        chk("t6_busy", busy_o, 1'b0);
        data_tx_req_i = 0;
        repeat (2) tick();
        rstn_i = 1;
        chk("t6_rel_ready", push_ready_o, 1'b0);
        tick();
        chk("t6_ready_back", push_ready_o, 1'b1);
        chk("t6_sent_zero", sent_count_o, '0);

        // randomized traffic: fill-heavy phase, then drain-heavy phase
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                push_valid_i    = ($urandom_range(99) < (ph == 0 ? 70 : 30));
                push_data_i     = $urandom;
                data_tx_req_i   = ($urandom_range(99) < 75);
                data_tx_ready_i = ($urandom_range(99) < (ph == 0 ? 30 : 80));
                flush_i         = ($urandom_range(63) == 0);
                tick();
            end
        end
        push_valid_i = 0; flush_i = 0; data_tx_req_i = 1; data_tx_ready_i = 1;
        repeat (60) tick();
        chk("final_level", fifo_level_o, '0);
        chk("final_busy", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
